// File: rtl/priv_1_12_pmp_fault_capture_pkg.sv
// Machine-mode shared types: access-fault exception codes and the
// fault-capture FSM state encoding.
package priv_1_12_pmp_fault_capture_pkg;

  // mcause exception codes for PMP access faults
  localparam logic [3:0] INSN_ACCESS_FAULT = 4'd1;
  localparam logic [3:0] L_ACCESS_FAULT    = 4'd5;
  localparam logic [3:0] S_ACCESS_FAULT    = 4'd7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    HOLDOFF = 2'd2
  } pmp_fault_state_t;

  // 8-bit increment that sticks at all-ones instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/priv_1_12_pmp_fault_capture.sv
// PMP fault capture: latches the highest-priority PMP access fault into a
// single pending trap request, holds it until the trap logic acks it, then
// waits one hold-off cycle before accepting another. Faults that cannot be
// captured are counted as drops.
module priv_1_12_pmp_fault_capture
  import priv_1_12_pmp_fault_capture_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        pmp_s_fault,
  input  logic        pmp_l_fault,
  input  logic        pmp_i_fault,
  input  logic [31:0] daddr,
  input  logic [31:0] iaddr,
  input  logic        trap_ack,
  input  logic        flush,
  output logic        trap_req,
  output logic [3:0]  trap_cause,
  output logic [31:0] trap_tval,
  output logic [7:0]  fault_count,
  output logic [7:0]  drop_count
);

  pmp_fault_state_t state_reg, state_next;
  logic [3:0]       cause_reg, cause_next;
  logic [31:0]      tval_reg, tval_next;
  logic [7:0]       fault_count_reg, fault_count_next;
  logic [7:0]       drop_count_reg, drop_count_next;
  logic             any_fault;

  assign any_fault = pmp_s_fault | pmp_l_fault | pmp_i_fault;

  // Next-state, capture (store > load > fetch priority) and counter updates
  always_comb begin
    state_next       = state_reg;
    cause_next       = cause_reg;
    tval_next        = tval_reg;
    fault_count_next = fault_count_reg;
    drop_count_next  = drop_count_reg;
    if (flush) begin
      // flush wins over ack and over any fault seen this cycle
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_fault) begin
            state_next       = PENDING;
            fault_count_next = sat_inc8(fault_count_reg);
            if (pmp_s_fault) begin
              cause_next = S_ACCESS_FAULT;
              tval_next  = daddr;
            end else if (pmp_l_fault) begin
              cause_next = L_ACCESS_FAULT;
              tval_next  = daddr;
            end else begin
              cause_next = INSN_ACCESS_FAULT;
              tval_next  = iaddr;
            end
          end
        end
        PENDING: begin
          if (any_fault) drop_count_next = sat_inc8(drop_count_reg);
          if (trap_ack)  state_next = HOLDOFF;
        end
        HOLDOFF: begin
          if (any_fault) drop_count_next = sat_inc8(drop_count_reg);
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State and counter registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg       <= IDLE;
      cause_reg       <= 4'd0;
      tval_reg        <= 32'd0;
      fault_count_reg <= 8'd0;
      drop_count_reg  <= 8'd0;
    end else begin
      state_reg       <= state_next;
      cause_reg       <= cause_next;
      tval_reg        <= tval_next;
      fault_count_reg <= fault_count_next;
      drop_count_reg  <= drop_count_next;
    end
  end

  // Cause/tval are only visible while the request is pending
  assign trap_req    = (state_reg == PENDING);
  assign trap_cause  = trap_req ? cause_reg : 4'd0;
  assign trap_tval   = trap_req ? tval_reg : 32'd0;
  assign fault_count = fault_count_reg;
  assign drop_count  = drop_count_reg;

endmodule

// File: tb/tb_priv_1_12_pmp_fault_capture.sv
// Scoreboard bench for priv_1_12_pmp_fault_capture: each driven cycle pushes
// the expected post-edge outputs; they are popped and compared after the edge.
module tb_priv_1_12_pmp_fault_capture;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        pmp_s_fault, pmp_l_fault, pmp_i_fault;
  logic [31:0] daddr, iaddr;
  logic        trap_ack, flush;
  logic        trap_req;
  logic [3:0]  trap_cause;
  logic [31:0] trap_tval;
  logic [7:0]  fault_count, drop_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        req;
    logic [3:0]  cause;
    logic [31:0] tval;
    logic [7:0]  fc;
    logic [7:0]  dc;
  } exp_t;

  exp_t exp_q[$];

  // reference model: 0=idle 1=pending 2=holdoff
  int          m_st = 0;
  logic [3:0]  m_cause = 4'd0;
  logic [31:0] m_tval = 32'd0;
  int          m_fc = 0;
  int          m_dc = 0;

  always #5 CLK = ~CLK;

  priv_1_12_pmp_fault_capture dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .pmp_s_fault (pmp_s_fault),
    .pmp_l_fault (pmp_l_fault),
    .pmp_i_fault (pmp_i_fault),
    .daddr       (daddr),
    .iaddr       (iaddr),
    .trap_ack    (trap_ack),
    .flush       (flush),
    .trap_req    (trap_req),
    .trap_cause  (trap_cause),
    .trap_tval   (trap_tval),
    .fault_count (fault_count),
    .drop_count  (drop_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model, push expectation, clock, pop and compare
  task automatic cyc(input logic rst_n, input logic s, input logic l, input logic i,
                     input logic [31:0] da, input logic [31:0] ia,
                     input logic ack, input logic fl);
    exp_t e;
    exp_t got;
    nRST = rst_n; pmp_s_fault = s; pmp_l_fault = l; pmp_i_fault = i;
    daddr = da; iaddr = ia; trap_ack = ack; flush = fl;
    if (!rst_n) begin
      m_st = 0; m_cause = 4'd0; m_tval = 32'd0; m_fc = 0; m_dc = 0;
    end else if (fl) begin
      m_st = 0;
    end else if (m_st == 0) begin
      if (s | l | i) begin
        m_st = 1;
        if (m_fc < 255) m_fc++;
        if (s)      begin m_cause = 4'd7; m_tval = da; end
        else if (l) begin m_cause = 4'd5; m_tval = da; end
        else        begin m_cause = 4'd1; m_tval = ia; end
      end
    end else if (m_st == 1) begin
      if ((s | l | i) && m_dc < 255) m_dc++;
      if (ack) m_st = 2;
    end else begin
      if ((s | l | i) && m_dc < 255) m_dc++;
      m_st = 0;
    end
    e.req   = (m_st == 1);
    e.cause = (m_st == 1) ? m_cause : 4'd0;
    e.tval  = (m_st == 1) ? m_tval : 32'd0;
    e.fc    = 8'(m_fc);
    e.dc    = 8'(m_dc);
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    got = exp_q.pop_front();
    $display("cyc t=%0t rst_n=%0b s=%0b l=%0b i=%0b ack=%0b fl=%0b -> req=%0b cause=%0d tval=0x%08h fc=%0d dc=%0d",
             $time, rst_n, s, l, i, ack, fl, trap_req, trap_cause, trap_tval, fault_count, drop_count);
    check("req",   {31'd0, trap_req},   {31'd0, got.req});
    check("cause", {28'd0, trap_cause}, {28'd0, got.cause});
    check("tval",  trap_tval,           got.tval);
    check("fcnt",  {24'd0, fault_count}, {24'd0, got.fc});
    check("dcnt",  {24'd0, drop_count},  {24'd0, got.dc});
  endtask

  task automatic idle_cyc();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    // reset
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check("rst_req", {31'd0, trap_req}, 32'd0);
    check("rst_fc",  {24'd0, fault_count}, 32'd0);

    // ack outside PENDING is ignored
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    check("ack_idle_req", {31'd0, trap_req}, 32'd0);

    // single load fault
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_0010, 32'd0, 1'b0, 1'b0);
    check("load_req",   {31'd0, trap_req}, 32'd1);
    check("load_cause", {28'd0, trap_cause}, 32'd5);
    check("load_tval",  trap_tval, 32'h8000_0010);
    check("load_fc",    {24'd0, fault_count}, 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    idle_cyc();

    // all three faults: store wins
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 32'h200, 1'b0, 1'b0);
    check("prio_cause", {28'd0, trap_cause}, 32'd7);
    check("prio_tval",  trap_tval, 32'h100);

    // fetch faults while pending are dropped, request unchanged
    for (int k = 0; k < 3; k++)
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h300 + 32'(k), 1'b0, 1'b0);
    check("drop_cause", {28'd0, trap_cause}, 32'd7);
    check("drop_tval",  trap_tval, 32'h100);
    check("drop_dc",    {24'd0, drop_count}, 32'd3);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    check("ack_req_low", {31'd0, trap_req}, 32'd0);
    idle_cyc();
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'h0000_4000, 1'b0, 1'b0);
    check("fetch_cause", {28'd0, trap_cause}, 32'd1);
    check("fetch_tval",  trap_tval, 32'h0000_4000);

    // flush beats ack and new fault
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h55, 32'd0, 1'b1, 1'b1);
    check("flush_req", {31'd0, trap_req}, 32'd0);
    check("flush_fc",  {24'd0, fault_count}, 32'd3);
    check("flush_dc",  {24'd0, drop_count}, 32'd3);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h66, 32'd0, 1'b0, 1'b0);
    check("post_flush_req", {31'd0, trap_req}, 32'd1);

    // reset while pending, fault held across release
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h44, 32'd0, 1'b0, 1'b0);
    check("rstp_req",  {31'd0, trap_req}, 32'd0);
    check("rstp_tval", trap_tval, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h44, 32'd0, 1'b0, 1'b0);
    check("rel_req",  {31'd0, trap_req}, 32'd1);
    check("rel_tval", trap_tval, 32'h44);
    check("rel_fc",   {24'd0, fault_count}, 32'd1);

    // random traffic
    for (int k = 0; k < 200; k++)
      cyc(($urandom_range(0, 29) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
          $urandom, $urandom, 1'($urandom), ($urandom_range(0, 9) == 0));

    // saturation: 300 captures with continuous faults
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int k = 0; k < 300; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'(k), 32'd0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'(k), 32'd0, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'(k), 32'd0, 1'b0, 1'b0);
    end
    check("sat_fc", {24'd0, fault_count}, 32'hFF);
    check("sat_dc", {24'd0, drop_count}, 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/priv_1_12_pmp_fault_capture.md
PRIV_1_12_PMP_FAULT_CAPTURE -- requirements
Module: priv_1_12_pmp_fault_capture

Interface
REQ-001 SHALL have port CLK  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port nRST  input  1  reset, synchronous and active-low.
REQ-003 SHALL have port pmp_s_fault  input  1  store/AMO PMP fault from the PMP checker, same cycle as the data access.
REQ-004 SHALL have port pmp_l_fault  input  1  load PMP fault from the PMP checker.
REQ-005 SHALL have port pmp_i_fault  input  1  instruction-fetch PMP fault from the PMP checker.
REQ-006 SHALL have port daddr  input  32  data address checked this cycle.
REQ-007 SHALL have port iaddr  input  32  fetch address checked this cycle.
REQ-008 SHALL have port trap_ack  input  1  trap logic has consumed the pending request.
REQ-009 SHALL have port flush  input  1  pipeline flush; discards any pending request.
REQ-010 SHALL have port trap_req  output  1  access-fault trap pending.
REQ-011 SHALL have port trap_cause  output  4  exception code of the pending fault.
REQ-012 SHALL have port trap_tval  output  32  faulting address (mtval value).
REQ-013 SHALL have port fault_count  output  8  saturating count of captured faults.
REQ-014 SHALL have port drop_count  output  8  saturating count of faults seen but not captured.

Function
REQ-015 SHALL implement FSM states IDLE, PENDING, HOLDOFF.
REQ-016 IDLE: any fault input high (and flush low) SHALL latch cause/tval and move to PENDING next cycle; latency fault->trap_req = 1 cycle.
REQ-017 Priority when several faults are high in one cycle SHALL be store (code 7, tval=daddr) > load (code 5, tval=daddr) > instruction (code 1, tval=iaddr).
REQ-018 PENDING: trap_req SHALL be 1; trap_cause/trap_tval SHALL stay stable until leaving PENDING.
REQ-019 PENDING with trap_ack=1 SHALL go to HOLDOFF next cycle; trap_req SHALL drop in that cycle.
REQ-020 HOLDOFF SHALL last exactly one cycle and then return to IDLE; faults in HOLDOFF are not captured.
REQ-021 flush=1 in any state SHALL force IDLE next cycle, clear trap_req, and block capture that cycle; flush has priority over trap_ack and new faults.
REQ-022 Faults arriving in PENDING or HOLDOFF (flush low) SHALL increment drop_count by 1 per cycle, regardless of how many fault bits are high.
REQ-023 Each capture in IDLE SHALL increment fault_count by 1.
REQ-024 Both counters SHALL saturate at 8'hFF, never wrap.
REQ-025 In IDLE and HOLDOFF trap_cause and trap_tval SHALL read 0.
REQ-026 trap_ack while not in PENDING SHALL be ignored.

Reset
REQ-027 nRST=0 sampled on a rising edge SHALL force IDLE, trap_req=0, trap_cause=0, trap_tval=0, fault_count=0, drop_count=0, overriding all other inputs.
REQ-028 Reset asserted while PENDING SHALL discard the request without an ack; first possible capture is the cycle after nRST returns high.

Structure
REQ-029 Exception-code constants (INSN_ACCESS_FAULT=1, L_ACCESS_FAULT=5, S_ACCESS_FAULT=7) and the FSM state enum SHALL reside in the shared machine-mode types package.
REQ-030 Block SHALL be a single module; no sub-module (counters and priority encoder inline).

Verification
REQ-031 pmp_l_fault=1, daddr=0x8000_0010 in IDLE -> next cycle trap_req=1, trap_cause=5, trap_tval=0x8000_0010, fault_count=1.
REQ-032 pmp_s_fault=pmp_l_fault=pmp_i_fault=1, daddr=0x100, iaddr=0x200 -> cause=7, tval=0x100.
REQ-033 PENDING, pmp_i_fault pulsed 3 cycles, then trap_ack -> cause/tval unchanged, drop_count=3, trap_req low 1 cycle after ack, IDLE 2 cycles after ack.
REQ-034 PENDING with flush=1 and trap_ack=1 and pmp_l_fault=1 same cycle -> IDLE next, trap_req=0, fault_count and drop_count unchanged.
REQ-035 Continuous faults with periodic ack for 300 captures -> fault_count holds 0xFF.
REQ-036 nRST=0 for one edge while PENDING -> all outputs 0 next cycle; fault held high captured the cycle after release.
